// File: rtl/mem_test_cmd_gen.sv
// Memory-test command generator: turns a latched test configuration into a
// stream of byte-addressed read/write burst commands over valid/ready.
module mem_test_cmd_gen #(
  parameter int AMM_DATA_W  = 128,
  parameter int AMM_ADDR_W  = 32,
  parameter int AMM_BURST_W = 11,
  parameter int CTRL_ADDR_W = 16,
  parameter int LFSR_W      = 32,
  parameter int CNT_W       = 16
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          start_i,
  input  logic                                          abort_i,
  input  logic [1:0]                                    test_mode_i,
  input  logic [2:0]                                    addr_mode_i,
  input  logic [CNT_W-1:0]                              trans_cnt_i,
  input  logic [AMM_ADDR_W-1:0]                         base_addr_i,
  input  logic [CTRL_ADDR_W-1:0]                        addr_step_i,
  input  logic [LFSR_W-1:0]                             seed_i,
  input  logic [AMM_BURST_W-2+$clog2(AMM_DATA_W/8):0]   byte_cnt_i,
  input  logic                                          downstream_busy_i,
  input  logic                                          cmd_ready_i,
  output logic                                          cmd_valid_o,
  output logic                                          cmd_write_o,
  output logic [AMM_ADDR_W-$clog2(AMM_DATA_W/8)-1:0]    cmd_word_addr_o,
  output logic [AMM_BURST_W-1:0]                        cmd_burst_o,
  output logic [$clog2(AMM_DATA_W/8)-1:0]               cmd_start_off_o,
  output logic [$clog2(AMM_DATA_W/8)-1:0]               cmd_end_off_o,
  output logic                                          busy_o,
  output logic                                          done_o,
  output logic                                          aborted_o,
  output logic                                          cfg_err_o
);

  localparam int BPW    = AMM_DATA_W / 8;
  localparam int BA_W   = $clog2(BPW);
  localparam int BCNT_W = AMM_BURST_W - 1 + BA_W;
  localparam int TOT_W  = AMM_BURST_W + BA_W;
  localparam int WA_W   = AMM_ADDR_W - BA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [2:0] AM_FIXED = 3'd0;
  localparam logic [2:0] AM_LFSR  = 3'd1;
  localparam logic [2:0] AM_RUN0  = 3'd2;
  localparam logic [2:0] AM_RUN1  = 3'd3;
  localparam logic [2:0] AM_INC   = 3'd4;
  localparam logic [2:0] AM_DEC   = 3'd5;

  // Fibonacci tap masks for x^8+x^6+x^5+x^4+1, x^16+x^15+x^13+x^4+1, x^32+x^22+x^2+x+1
  localparam logic [31:0] TAPS_ALL = (LFSR_W == 8)  ? 32'h0000_00B8 :
                                     (LFSR_W == 16) ? 32'h0000_D008 : 32'h8020_0003;
  localparam logic [LFSR_W-1:0] TAPS = TAPS_ALL[LFSR_W-1:0];

  logic [1:0]             state_q, state_d;
  logic [1:0]             tmode_q, tmode_d;
  logic [2:0]             amode_q, amode_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic [AMM_ADDR_W-1:0]  base_q, base_d;
  logic [CTRL_ADDR_W-1:0] step_q, step_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]      lfsrInit_q, lfsrInit_d;
  logic [CTRL_ADDR_W-1:0] pat_q, pat_d;
  logic [CNT_W:0]         acc_q, acc_d;
  logic                   valid_q, valid_d;
  logic                   write_q, write_d;
  logic [WA_W-1:0]        waddr_q, waddr_d;
  logic [AMM_BURST_W-1:0] burst_q, burst_d;
  logic [BA_W-1:0]        soff_q, soff_d;
  logic [BA_W-1:0]        eoff_q, eoff_d;
  logic                   aborted_q, aborted_d;
  logic                   first_q, first_d;
  logic                   done_q, done_d;
  logic                   cfgErr_q, cfgErr_d;

  logic                   load, advance, reload;
  logic [AMM_ADDR_W-1:0]  fBase, byteAddr;
  logic [BCNT_W-1:0]      fBcnt;
  logic [TOT_W-1:0]       total;
  logic [CNT_W:0]         accNext, cmdTotal;

  function automatic logic [CTRL_ADDR_W-1:0] initPat(input logic [2:0] am,
                                                     input logic [LFSR_W-1:0] l);
    case (am)
      AM_LFSR: return l[CTRL_ADDR_W-1:0];
      AM_RUN0: return {{(CTRL_ADDR_W-1){1'b1}}, 1'b0};
      AM_RUN1: return {{(CTRL_ADDR_W-1){1'b0}}, 1'b1};
      default: return '0;
    endcase
  endfunction

  function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & TAPS)};
  endfunction

  always_comb begin
    state_d = state_q;  tmode_d = tmode_q;  amode_d = amode_q;  n_d = n_q;
    base_d = base_q;  step_d = step_q;  bcnt_d = bcnt_q;
    lfsr_d = lfsr_q;  lfsrInit_d = lfsrInit_q;  pat_d = pat_q;  acc_d = acc_q;
    valid_d = valid_q;  write_d = write_q;  waddr_d = waddr_q;  burst_d = burst_q;
    soff_d = soff_q;  eoff_d = eoff_q;  aborted_d = aborted_q;  first_d = first_q;
    done_d = 1'b0;  cfgErr_d = 1'b0;
    load = 1'b0;  advance = 1'b0;  reload = 1'b0;
    fBase = base_q;  fBcnt = bcnt_q;
    accNext = acc_q + (CNT_W+1)'(1);
    cmdTotal = tmode_q[1] ? {n_q, 1'b0} : {1'b0, n_q};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (trans_cnt_i == '0 || byte_cnt_i == '0 || addr_mode_i > AM_DEC) begin
            cfgErr_d = 1'b1;
          end else begin
            tmode_d = test_mode_i;  amode_d = addr_mode_i;  n_d = trans_cnt_i;
            base_d = base_addr_i;  step_d = addr_step_i;  bcnt_d = byte_cnt_i;
            lfsr_d = (seed_i == '0) ? '1 : seed_i;
            lfsrInit_d = lfsr_d;
            pat_d = initPat(addr_mode_i, lfsr_d);
            write_d = (test_mode_i != 2'd0);
            valid_d = 1'b1;  acc_d = '0;  aborted_d = 1'b0;
            state_d = S_RUN;
            load = 1'b1;  fBase = base_addr_i;  fBcnt = byte_cnt_i;
          end
        end
      end
      S_RUN: begin
        if (abort_i) begin
          valid_d = 1'b0;  aborted_d = 1'b1;  first_d = 1'b1;  state_d = S_DRAIN;
        end else if (cmd_ready_i) begin
          if (accNext == cmdTotal) begin
            valid_d = 1'b0;  first_d = 1'b1;  state_d = S_DRAIN;
          end else begin
            acc_d = accNext;
            load = 1'b1;
            // Interleaved mode reuses the address for the read; write-then-read rewinds once.
            case (tmode_q)
              2'd2: begin
                write_d = !write_q;
                advance = !write_q;
              end
              2'd3: begin
                if (accNext == {1'b0, n_q}) begin
                  write_d = 1'b0;
                  reload = 1'b1;
                end else begin
                  advance = 1'b1;
                end
              end
              default: advance = 1'b1;
            endcase
          end
        end
      end
      S_DRAIN: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!downstream_busy_i) begin
          done_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      case (amode_q)
        AM_LFSR: begin
          lfsr_d = lfsrNext(lfsr_q);
          pat_d = lfsr_d[CTRL_ADDR_W-1:0];
        end
        AM_RUN0, AM_RUN1: pat_d = {pat_q[CTRL_ADDR_W-2:0], pat_q[CTRL_ADDR_W-1]};
        AM_INC:  pat_d = pat_q + step_q;
        AM_DEC:  pat_d = pat_q - step_q;
        default: pat_d = '0;
      endcase
    end
    if (reload) begin
      lfsr_d = lfsrInit_q;
      pat_d = initPat(amode_q, lfsrInit_q);
    end

    byteAddr = fBase + AMM_ADDR_W'(pat_d);
    total = TOT_W'(byteAddr[BA_W-1:0]) + TOT_W'(fBcnt);
    if (load) begin
      waddr_d = byteAddr[AMM_ADDR_W-1:BA_W];
      soff_d = byteAddr[BA_W-1:0];
      burst_d = AMM_BURST_W'((total + TOT_W'(BPW - 1)) >> BA_W);
      eoff_d = BA_W'(total - TOT_W'(1));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;  tmode_q <= '0;  amode_q <= '0;  n_q <= '0;
      base_q <= '0;  step_q <= '0;  bcnt_q <= '0;
      lfsr_q <= '0;  lfsrInit_q <= '0;  pat_q <= '0;  acc_q <= '0;
      valid_q <= 1'b0;  write_q <= 1'b0;  waddr_q <= '0;  burst_q <= '0;
      soff_q <= '0;  eoff_q <= '0;  aborted_q <= 1'b0;  first_q <= 1'b0;
      done_q <= 1'b0;  cfgErr_q <= 1'b0;
    end else begin
      state_q <= state_d;  tmode_q <= tmode_d;  amode_q <= amode_d;  n_q <= n_d;
      base_q <= base_d;  step_q <= step_d;  bcnt_q <= bcnt_d;
      lfsr_q <= lfsr_d;  lfsrInit_q <= lfsrInit_d;  pat_q <= pat_d;  acc_q <= acc_d;
      valid_q <= valid_d;  write_q <= write_d;  waddr_q <= waddr_d;  burst_q <= burst_d;
      soff_q <= soff_d;  eoff_q <= eoff_d;  aborted_q <= aborted_d;  first_q <= first_d;
      done_q <= done_d;  cfgErr_q <= cfgErr_d;
    end
  end

  assign cmd_valid_o     = valid_q;
  assign cmd_write_o     = write_q;
  assign cmd_word_addr_o = waddr_q;
  assign cmd_burst_o     = burst_q;
  assign cmd_start_off_o = soff_q;
  assign cmd_end_off_o   = eoff_q;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done_q;
  assign aborted_o       = aborted_q;
  assign cfg_err_o       = cfgErr_q;

endmodule

// File: doc/mem_test_cmd_gen.md
Name: mem_test_cmd_gen

Overview:
Parameterised command generator for the memory checker. It takes a latched test configuration and issues a stream of byte-addressed read/write burst commands to the transaction block over a valid/ready handshake. Supports four test modes and six address patterns, validates the configuration, handles abort, and waits for the downstream blocks to go idle before signalling completion. Sits between the CSR block and the transaction, compare and measurement blocks.

Parameters:
AMM_DATA_W, 128, memory data width in bits; BPW = AMM_DATA_W/8, BYTE_ADDR_W = log2(BPW)
AMM_ADDR_W, 32, byte-address width
AMM_BURST_W, 11, burst-count width (at least 2)
CTRL_ADDR_W, 16, pattern register width (at most LFSR_W, at most AMM_ADDR_W)
LFSR_W, 32, LFSR width; legal values 8, 16 or 32
CNT_W, 16, transaction-count width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  start pulse; sampled only in IDLE
abort_i  in  1  error abort request
test_mode_i  in  2  test mode: 0 = read-only, 1 = write-only, 2 = write/read interleaved, 3 = write-all then read-all
addr_mode_i  in  3  address pattern: 0 = fixed, 1 = LFSR, 2 = running-0, 3 = running-1, 4 = increment, 5 = decrement
trans_cnt_i  in  CNT_W  N, the number of addresses
base_addr_i  in  AMM_ADDR_W  base byte address
addr_step_i  in  CTRL_ADDR_W  step for increment/decrement modes
seed_i  in  LFSR_W  LFSR seed
byte_cnt_i  in  AMM_BURST_W-1+BYTE_ADDR_W  bytes per command
downstream_busy_i  in  1  OR of the transaction, compare and measurement busy flags
cmd_ready_i  in  1  downstream accepts the command
cmd_valid_o  out  1  command valid
cmd_write_o  out  1  1 = write, 0 = read
cmd_word_addr_o  out  AMM_ADDR_W-BYTE_ADDR_W  word address
cmd_burst_o  out  AMM_BURST_W  burst length in words
cmd_start_off_o  out  BYTE_ADDR_W  byte offset of the first byte in the first word
cmd_end_off_o  out  BYTE_ADDR_W  byte offset of the last byte in the last word
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle completion pulse
aborted_o  out  1  last test was aborted; cleared on next accepted start
cfg_err_o  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset: all outputs 0; state IDLE; pattern and LFSR registers 0.
- States: IDLE, RUN, DRAIN.
- Start in IDLE:
  - Rejected if trans_cnt_i == 0, byte_cnt_i == 0, or addr_mode_i > 5. Response: cfg_err_o pulses the next cycle; state stays IDLE.
  - Otherwise, on the next cycle: all inputs latched, state RUN, cmd_valid_o = 1 with the first command.
  - start_i outside IDLE is ignored.
- Handshake:
  - Command fields are registered and held stable while cmd_valid_o && !cmd_ready_i.
  - On acceptance the next command appears the following cycle with cmd_valid_o still high, giving 1 command per cycle.
  - After the last acceptance: cmd_valid_o = 0 and state DRAIN the next cycle.
- Command counts: modes 0/1 issue N commands; modes 2/3 issue 2N.
- Command order:
  - Mode 2: W(A0), R(A0), W(A1), R(A1), ...
  - Mode 3: W(A0..AN-1), then the pattern reloads to its initial value, then R(A0..AN-1).
- Pattern advance: on every acceptance, except in mode 2 where it advances only on acceptance of the read.
- Address patterns (P is CTRL_ADDR_W bits, all arithmetic modulo 2^CTRL_ADDR_W):
  - Fixed: P = 0 throughout.
  - Increment: P = 0, then P + step.
  - Decrement: P = 0, then P - step (0 - 4 wraps to 0xFFFC).
  - Running-0: initial all ones with bit0 = 0; rotate left by one.
  - Running-1: initial 0...01; rotate left by one.
  - LFSR: Fibonacci, shift left, feedback into bit0. Taps: x^8+x^6+x^5+x^4+1, x^16+x^15+x^13+x^4+1, x^32+x^22+x^2+x+1. A seed of 0 is replaced by all ones. P = LFSR[CTRL_ADDR_W-1:0].
- Address arithmetic:
  - byte_addr = (base + zero-extended P) mod 2^AMM_ADDR_W.
  - start_off = byte_addr[BYTE_ADDR_W-1:0].
  - total = start_off + byte_cnt, computed in AMM_BURST_W+BYTE_ADDR_W bits.
  - cmd_burst_o = (total + BPW - 1) >> BYTE_ADDR_W.
  - cmd_end_off_o = (total - 1)[BYTE_ADDR_W-1:0].
  - cmd_word_addr_o = byte_addr >> BYTE_ADDR_W.
- Abort: abort_i high in RUN causes cmd_valid_o = 0 the next cycle regardless of cmd_ready_i, state DRAIN, aborted_o = 1. abort_i is ignored in IDLE and DRAIN.
- DRAIN:
  - downstream_busy_i is ignored on the first DRAIN cycle.
  - From the second cycle on, when downstream_busy_i == 0: done_o pulses and state returns to IDLE the next cycle.
- Reset mid-operation: returns immediately to the reset values; no done_o.

Test Plan:
- AMM_DATA_W=32, mode 1, increment, base 0x100, step 4, byte_cnt 4, N=3, ready=1, busy=0 -> three writes at word addresses 0x40, 0x41, 0x42; burst 1; offsets 0/3; done_o pulses exactly once, the cycle after the second DRAIN cycle.
- Fixed mode, base 0x103, byte_cnt 6 -> start_off 3, burst 3, end_off 0, word address 0x40; mode 2, N=2 -> W, R, W, R, all at the same address.
- Mode 3, LFSR_W=8, seed 0 -> write addresses follow the LFSR sequence from 0xFF; read addresses repeat the same sequence; 2N commands total.
- Hold cmd_ready_i=0 for 5 cycles mid-stream -> all fields stable and cmd_valid_o held; no address advance.
- abort_i on the 2nd command with ready=0 -> valid drops the next cycle; aborted_o=1; done_o only after downstream_busy_i falls.
- start with trans_cnt_i=0 or addr_mode_i=6 -> cfg_err_o pulse; busy_o stays 0.
